cpu_mc_control: RTL
===================

// Module: cpu_mc_control
// PURPOSE
//  Multi-cycle control FSM for the 16-bit CPU; successor to the single-cycle opcode decoder.
//  Sequences FETCH/DECODE/EXEC/MEM/WB/BRANCH/HALT per instruction and handshakes with
//  instruction and data memories that have variable latency.
//  Emits the datapath strobes, a retired-instruction counter and a sticky bus-timeout error.
// PARAMETERS
//  OP_W     4   opcode width; opcode values come from cpu_pkg
//  ALUOP_W  3   alu_op width
//  WAIT_MAX 16  max wait cycles for a memory ready; 0 disables the timeout
//  CNT_W    32  instr_count width
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        synchronous, active-high reset
//  opcode       in   OP_W     IR[15:12]; stable from DECODE until instruction end
//  cond_true    in   1        branch condition met (flags vs ccc); sampled in BRANCH
//  imem_ready   in   1        instruction word valid this cycle
//  dmem_ready   in   1        data access complete this cycle
//  imem_req     out  1        instruction fetch request
//  dmem_req     out  1        data memory request
//  ir_write     out  1        load IR
//  pc_write     out  1        load PC
//  pc_source    out  2        00 PC+2, 01 register (BR), 11 PC+2+imm (B)
//  reg_read     out  1        register-file read enable
//  reg_write    out  1        register-file write enable
//  mem_read     out  1        data read (LW)
//  mem_write    out  1        data write (SW)
//  mem_to_reg   out  2        00 PC+2, 01 imm, 10 ALU, 11 memory
//  alu_op       out  ALUOP_W  ALU function
//  alu_src      out  1        1 = immediate operand
//  lh           out  1        1 = LHB high-byte load
//  flag_write   out  1        update ALU flags (opcodes 0000-0111)
//  halted       out  1        core stopped
//  bus_err      out  1        sticky memory timeout
//  instr_count  out  CNT_W    instructions retired
// BEHAVIOUR
//  - While rst is high: state<=FETCH, wait_cnt<=0, instr_count<=0, bus_err<=0, all outputs 0.
//  - Outputs are Moore decodes of the state register and opcode. Strobes are 0 unless listed.
//  - FETCH: imem_req=1. On imem_ready: ir_write=1, pc_write=1, pc_source=00, go to DECODE.
//  - DECODE: reg_read=1. Next state by opcode:
//    1111 HLT -> HALT; 1100 B or 1101 BR -> BRANCH; otherwise -> EXEC.
//  - EXEC: ALU ops 0000-0111 use alu_op=opcode[2:0]; LW/SW use alu_op=000.
//    alu_src=1 for SLL/SRA/ROR/LW/SW. Next: LW/SW -> MEM; all others -> WB.
//  - MEM: dmem_req=1; mem_read=1 for LW, mem_write=1 for SW; held until dmem_ready.
//    On ready: LW -> WB; SW retires -> FETCH.
//  - WB: reg_write=1.
//    mem_to_reg: ALU ops 10, LW 11, LLB/LHB 01, PCS 00; lh=1 for LHB.
//    flag_write=1 for ALU ops. Retires -> FETCH.
//  - BRANCH: if cond_true then pc_write=1, pc_source=11 (B) or 01 (BR); else no PC write.
//    Retires -> FETCH.
//  - HALT: halted=1, all strobes 0; absorbing until rst. HLT counts as retired on DECODE exit.
//  - Retire: instr_count+=1 on the retiring edge; wraps modulo 2^CNT_W.
//  - Latency (zero-wait memory):
//    ALU/LLB/LHB/PCS 4 cycles, LW 5, SW 4, B/BR 3; each wait cycle adds 1.
//  - Timeout: wait_cnt counts cycles in FETCH/MEM without ready and clears on state change.
//    If WAIT_MAX!=0 and wait_cnt==WAIT_MAX-1 with ready low: go to HALT and set bus_err.
//    A ready that arrives in the same cycle wins over the timeout.
//  - An undefined opcode, or X in DECODE, is treated as a NOP: DECODE -> FETCH, retired.
//  - rst asserted mid-instruction aborts it; no strobe is asserted on that edge.
//  - No simultaneous imem_req and dmem_req, ever.
// STRUCTURE
//  - cpu_pkg holds: opcode localparams (OP_ADD..OP_HLT), state enum (S_FETCH..S_HALT),
//    mem_to_reg and pc_source encodings.
//  - Sub-module cpu_ctrl_decode: combinational opcode -> class bits
//    (is_alu, is_shift, is_lw, is_sw, is_imm, is_pcs, is_br, is_b, is_hlt).
//    The FSM, wait counter and instruction counter live in cpu_mc_control.
// TESTING
//  1. Reset, ready tied 1, ADD (0000) -> FETCH,DECODE,EXEC,WB in 4 cycles;
//     WB: reg_write=1, mem_to_reg=10, flag_write=1, alu_op=000; instr_count=1.
//  2. LW with dmem_ready low 3 cycles -> mem_read held 4 cycles;
//     WB: mem_to_reg=11; total 8 cycles.
//  3. B, cond_true=1 -> BRANCH: pc_write=1, pc_source=11.
//     BR, cond_true=0 -> pc_write=0; both retire in 3 cycles.
//  4. WAIT_MAX=4, imem_ready stuck 0 -> after 4 FETCH cycles: halted=1, bus_err=1, stays.
//     Ready arriving on cycle 4 -> no error.
//  5. HLT -> halted=1 from cycle 3, no further imem_req; rst -> FETCH, counters 0.
//  6. LHB then SW then rst mid-MEM -> WB lh=1, mem_to_reg=01;
//     SW aborted with no mem_write on the reset edge.

Source files
------------

// File: rtl/cpu_mc_control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mc_control_pkg
// Description : Shared opcodes, FSM states, datapath select encodings and the
//               opcode class record for the multi-cycle CPU control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_mc_control_pkg;

    // Opcode map for IR[15:12]
    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_RED    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LLB    = 4'hA;
    localparam logic [3:0] OP_LHB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BRANCH = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    // PC source select
    localparam logic [1:0] PCSRC_NEXT = 2'b00;
    localparam logic [1:0] PCSRC_REG  = 2'b01;
    localparam logic [1:0] PCSRC_REL  = 2'b11;

    // Register write-back source select
    localparam logic [1:0] M2R_PC  = 2'b00;
    localparam logic [1:0] M2R_IMM = 2'b01;
    localparam logic [1:0] M2R_ALU = 2'b10;
    localparam logic [1:0] M2R_MEM = 2'b11;

    typedef struct packed {
        logic is_alu;
        logic is_shift;
        logic is_lw;
        logic is_sw;
        logic is_imm;
        logic is_lhb;
        logic is_pcs;
        logic is_br;
        logic is_b;
        logic is_hlt;
    } op_class_t;

endpackage
`default_nettype wire

// File: rtl/cpu_mc_control_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mc_control_if
// Description : Control-unit bundle: opcode/condition/memory-ready inputs and
//               all datapath strobes, status and retired count.
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_mc_control_if #(
    parameter int OP_W    = 4,
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 32
);
    logic [OP_W-1:0]    opcode;
    logic               cond_true;
    logic               imem_ready;
    logic               dmem_ready;
    logic               imem_req;
    logic               dmem_req;
    logic               ir_write;
    logic               pc_write;
    logic [1:0]         pc_source;
    logic               reg_read;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic [1:0]         mem_to_reg;
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
    logic               lh;
    logic               flag_write;
    logic               halted;
    logic               bus_err;
    logic [CNT_W-1:0]   instr_count;

    // Controller side
    modport master (
        input  opcode, cond_true, imem_ready, dmem_ready,
        output imem_req, dmem_req, ir_write, pc_write, pc_source, reg_read,
               reg_write, mem_read, mem_write, mem_to_reg, alu_op, alu_src,
               lh, flag_write, halted, bus_err, instr_count
    );

    // Datapath / memory side
    modport slave (
        output opcode, cond_true, imem_ready, dmem_ready,
        input  imem_req, dmem_req, ir_write, pc_write, pc_source, reg_read,
               reg_write, mem_read, mem_write, mem_to_reg, alu_op, alu_src,
               lh, flag_write, halted, bus_err, instr_count
    );
endinterface
`default_nettype wire

// File: rtl/cpu_mc_control_decode.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mc_control_decode
// Description : Combinational opcode classifier. Unknown codes yield an
//               all-zero class, which the FSM treats as a NOP.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_mc_control_decode
    import cpu_mc_control_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic [OP_W-1:0] i_opcode,
    output op_class_t       o_class
);

    logic [3:0] w_op;
    assign w_op = i_opcode[3:0];

    // Map each opcode to its class bits
    always_comb begin
        o_class = '0;
        case (w_op)
            OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB: o_class.is_alu = 1'b1;
            OP_SLL, OP_SRA, OP_ROR: begin
                o_class.is_alu   = 1'b1;
                o_class.is_shift = 1'b1;
            end
            OP_LW:  o_class.is_lw  = 1'b1;
            OP_SW:  o_class.is_sw  = 1'b1;
            OP_LLB: o_class.is_imm = 1'b1;
            OP_LHB: begin
                o_class.is_imm = 1'b1;
                o_class.is_lhb = 1'b1;
            end
            OP_B:   o_class.is_b   = 1'b1;
            OP_BR:  o_class.is_br  = 1'b1;
            OP_PCS: o_class.is_pcs = 1'b1;
            OP_HLT: o_class.is_hlt = 1'b1;
            default: o_class = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu_mc_control.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mc_control
// Description : Multi-cycle control FSM. Sequences fetch/decode/execute/
//               memory/write-back/branch/halt, handshakes with variable-
//               latency memories, counts retired instructions and latches a
//               sticky bus-timeout error.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_mc_control
    import cpu_mc_control_pkg::*;
#(
    parameter int OP_W     = 4,
    parameter int ALUOP_W  = 3,
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    cpu_mc_control_if.master bus
);

    localparam int c_wc_w = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
    localparam logic [c_wc_w-1:0] c_wait_last = c_wc_w'((WAIT_MAX == 0) ? 0 : WAIT_MAX - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_wc_w-1:0]   r_wait_cnt;
    logic [CNT_W-1:0]    r_instr_count;
    logic                r_bus_err;
    op_class_t           w_cls;
    logic                w_wait_last;
    logic                w_retire;
    logic                w_timeout;

    logic                w_imem_req, w_dmem_req, w_ir_write, w_pc_write;
    logic [1:0]          w_pc_source, w_mem_to_reg;
    logic                w_reg_read, w_reg_write, w_mem_read, w_mem_write;
    logic [ALUOP_W-1:0]  w_alu_op;
    logic                w_alu_src, w_lh, w_flag_write, w_halted;

    cpu_mc_control_decode #(.OP_W(OP_W)) u_decode (
        .i_opcode (bus.opcode),
        .o_class  (w_cls)
    );

    assign w_wait_last = (WAIT_MAX != 0) && (r_wait_cnt == c_wait_last);

    // State register, wait counter, retire counter and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_FETCH;
            r_wait_cnt    <= '0;
            r_instr_count <= '0;
            r_bus_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state)
                r_wait_cnt <= '0;
            else if (r_state == S_FETCH || r_state == S_MEM)
                r_wait_cnt <= r_wait_cnt + c_wc_w'(1);
            if (w_retire)
                r_instr_count <= r_instr_count + CNT_W'(1);
            if (w_timeout)
                r_bus_err <= 1'b1;
        end
    end

    // Next-state and strobe decode; everything forced low while in reset
    always_comb begin
        w_state_nxt  = r_state;
        w_retire     = 1'b0;
        w_timeout    = 1'b0;
        w_imem_req   = 1'b0;
        w_dmem_req   = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_pc_source  = PCSRC_NEXT;
        w_reg_read   = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_to_reg = M2R_PC;
        w_alu_op     = '0;
        w_alu_src    = 1'b0;
        w_lh         = 1'b0;
        w_flag_write = 1'b0;
        w_halted     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_imem_req = 1'b1;
                if (bus.imem_ready) begin
                    w_ir_write  = 1'b1;
                    w_pc_write  = 1'b1;
                    w_state_nxt = S_DECODE;
                end else if (w_wait_last) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_HALT;
                end
            end
            S_DECODE: begin
                w_reg_read = 1'b1;
                if (w_cls.is_hlt) begin
                    w_retire    = 1'b1;
                    w_state_nxt = S_HALT;
                end else if (w_cls.is_b || w_cls.is_br) begin
                    w_state_nxt = S_BRANCH;
                end else if (w_cls.is_alu || w_cls.is_lw || w_cls.is_sw ||
                             w_cls.is_imm || w_cls.is_pcs) begin
                    w_state_nxt = S_EXEC;
                end else begin
                    w_retire    = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            S_EXEC: begin
                if (w_cls.is_alu)
                    w_alu_op = ALUOP_W'(bus.opcode[2:0]);
                w_alu_src   = w_cls.is_shift | w_cls.is_lw | w_cls.is_sw;
                w_state_nxt = (w_cls.is_lw || w_cls.is_sw) ? S_MEM : S_WB;
            end
            S_MEM: begin
                w_dmem_req  = 1'b1;
                w_mem_read  = w_cls.is_lw;
                w_mem_write = w_cls.is_sw;
                if (bus.dmem_ready) begin
                    w_retire    = w_cls.is_sw;
                    w_state_nxt = w_cls.is_lw ? S_WB : S_FETCH;
                end else if (w_wait_last) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_HALT;
                end
            end
            S_WB: begin
                w_reg_write  = 1'b1;
                w_flag_write = w_cls.is_alu;
                w_lh         = w_cls.is_lhb;
                if (w_cls.is_alu)      w_mem_to_reg = M2R_ALU;
                else if (w_cls.is_lw)  w_mem_to_reg = M2R_MEM;
                else if (w_cls.is_imm) w_mem_to_reg = M2R_IMM;
                else                   w_mem_to_reg = M2R_PC;
                w_retire    = 1'b1;
                w_state_nxt = S_FETCH;
            end
            S_BRANCH: begin
                if (bus.cond_true) begin
                    w_pc_write  = 1'b1;
                    w_pc_source = w_cls.is_b ? PCSRC_REL : PCSRC_REG;
                end
                w_retire    = 1'b1;
                w_state_nxt = S_FETCH;
            end
            S_HALT: begin
                w_halted = 1'b1;
            end
            default: w_state_nxt = S_FETCH;
        endcase
        if (rst) begin
            w_retire     = 1'b0;
            w_timeout    = 1'b0;
            w_imem_req   = 1'b0;
            w_dmem_req   = 1'b0;
            w_ir_write   = 1'b0;
            w_pc_write   = 1'b0;
            w_pc_source  = PCSRC_NEXT;
            w_reg_read   = 1'b0;
            w_reg_write  = 1'b0;
            w_mem_read   = 1'b0;
            w_mem_write  = 1'b0;
            w_mem_to_reg = M2R_PC;
            w_alu_op     = '0;
            w_alu_src    = 1'b0;
            w_lh         = 1'b0;
            w_flag_write = 1'b0;
            w_halted     = 1'b0;
        end
    end

    assign bus.imem_req    = w_imem_req;
    assign bus.dmem_req    = w_dmem_req;
    assign bus.ir_write    = w_ir_write;
    assign bus.pc_write    = w_pc_write;
    assign bus.pc_source   = w_pc_source;
    assign bus.reg_read    = w_reg_read;
    assign bus.reg_write   = w_reg_write;
    assign bus.mem_read    = w_mem_read;
    assign bus.mem_write   = w_mem_write;
    assign bus.mem_to_reg  = w_mem_to_reg;
    assign bus.alu_op      = w_alu_op;
    assign bus.alu_src     = w_alu_src;
    assign bus.lh          = w_lh;
    assign bus.flag_write  = w_flag_write;
    assign bus.halted      = w_halted;
    assign bus.bus_err     = r_bus_err & ~rst;
    assign bus.instr_count = rst ? '0 : r_instr_count;

endmodule
`default_nettype wire
